// File: rtl/rect_fill.sv
// rtl/rect_fill.sv - rectangle-fill engine feeding the frame-buffer write port
// Clips each command to the display and streams one pixel write per cycle, x-inner.
module rect_fill #(
  parameter int HD     = 1280,
  parameter int VD     = 1024,
  parameter int X_BITS = 11,
  parameter int Y_BITS = 11
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [X_BITS-1:0] cmd_x0_i,
  input  logic [Y_BITS-1:0] cmd_y0_i,
  input  logic [X_BITS-1:0] cmd_x1_i,
  input  logic [Y_BITS-1:0] cmd_y1_i,
  input  logic [1:0]        cmd_color_i,
  input  logic              stall_i,
  output logic              we_o,
  output logic [X_BITS-1:0] addr_x_o,
  output logic [Y_BITS-1:0] addr_y_o,
  output logic [1:0]        color_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(HD - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(VD - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state, state_nx;
  logic [X_BITS-1:0] x0_q, x1c_q, cx;
  logic [Y_BITS-1:0] y1c_q, cy;
  logic [1:0]        color_q;
  logic [X_BITS-1:0] x1c;
  logic [Y_BITS-1:0] y1c;
  logic              empty, accept, last, advance;

  assign x1c     = (cmd_x1_i > X_MAX) ? X_MAX : cmd_x1_i;
  assign y1c     = (cmd_y1_i > Y_MAX) ? Y_MAX : cmd_y1_i;
  assign empty   = (cmd_x0_i > x1c) || (cmd_y0_i > y1c) ||
                   (cmd_x0_i > X_MAX) || (cmd_y0_i > Y_MAX);
  assign accept  = cmd_valid_i && (state == IDLE);
  assign last    = (cx == x1c_q) && (cy == y1c_q);
  assign advance = (state == FILL) && !stall_i;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cmd_ready_o = 1'b0;
    we_o        = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = arstn;
        if (accept) state_nx = empty ? DONE : FILL;
      end
      FILL: begin
        busy_o = arstn;
        we_o   = arstn && !stall_i;
        if (!stall_i && last) state_nx = DONE;
      end
      DONE: begin
        busy_o   = arstn;
        done_o   = arstn;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The cursor doubles as the write address; it stops on the last pixel so
  // the address outputs keep showing the final write after the command ends.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      x0_q    <= '0;
      x1c_q   <= '0;
      y1c_q   <= '0;
      color_q <= '0;
      cx      <= '0;
      cy      <= '0;
    end else if (accept) begin
      x0_q    <= cmd_x0_i;
      x1c_q   <= x1c;
      y1c_q   <= y1c;
      color_q <= cmd_color_i;
      cx      <= cmd_x0_i;
      cy      <= cmd_y0_i;
    end else if (advance && !last) begin
      if (cx == x1c_q) begin
        cx <= x0_q;
        cy <= cy + Y_BITS'(1);
      end else begin
        cx <= cx + X_BITS'(1);
      end
    end
  end

  assign addr_x_o = cx;
  assign addr_y_o = cy;
  assign color_o  = color_q;

endmodule

// File: tb/tb_rect_fill.sv
// tb/tb_rect_fill.sv - directed bench for rect_fill with a per-cycle reference model
// Expected write streams come from clip arithmetic and pixel-index math, plus literal pins.
module tb_rect_fill;
  localparam int HD = 1280;
  localparam int VD = 1024;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [1:0]  cmd_color = '0;
  logic        stall = 1'b0;
  logic        we, busy, done;
  logic [10:0] addr_x, addr_y;
  logic [1:0]  color;

  rect_fill #(.HD(HD), .VD(VD), .X_BITS(11), .Y_BITS(11)) dut (
    .clk(clk), .arstn(arstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color), .stall_i(stall),
    .we_o(we), .addr_x_o(addr_x), .addr_y_o(addr_y), .color_o(color),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  logic        chk_en = 1'b0;
  logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ready = 1'b0;
  logic [10:0] e_x = '0, e_y = '0;
  logic [1:0]  e_c = '0;
  int          log_x[$];
  int          log_y[$];
  int          done_lbl = -1;
  int          t_acc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Cycle labels: the cycle right after the accepting edge is label 1.
  always @(negedge clk) begin
    if (chk_en) begin
      check("we", we, e_we);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("ready", cmd_ready, e_ready);
      if (e_we) begin
        check("addr_x", addr_x, e_x);
        check("addr_y", addr_y, e_y);
        check("color", color, e_c);
      end
      if (we) begin
        log_x.push_back(int'(addr_x));
        log_y.push_back(int'(addr_y));
      end
      if (done) done_lbl = cyc - t_acc + 1;
    end
  end

  task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
    log_x.delete();
    log_y.delete();
    done_lbl = -1;
    cmd_x0 = 11'(ax0); cmd_y0 = 11'(ay0); cmd_x1 = 11'(ax1); cmd_y1 = 11'(ay1);
    cmd_color = 2'(c);
    cmd_valid = 1'b1;
    e_we = 0; e_busy = 0; e_done = 0; e_ready = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int c, input logic [31:0] stall_mask);
    int x1c, y1c, w, n, p, k;
    x1c = (ax1 > HD - 1) ? HD - 1 : ax1;
    y1c = (ay1 > VD - 1) ? VD - 1 : ay1;
    w = x1c - ax0 + 1;
    if (ax0 > x1c || ay0 > y1c || ax0 >= HD || ay0 >= VD) n = 0;
    else n = w * (y1c - ay0 + 1);
    issue(ax0, ay0, ax1, ay1, c);
    p = 0;
    k = 1;
    while (p < n) begin
      stall = stall_mask[k];
      e_ready = 0; e_busy = 1; e_done = 0; e_we = !stall;
      if (!stall) begin
        e_x = 11'(ax0 + p % w);
        e_y = 11'(ay0 + p / w);
        e_c = 2'(c);
        p++;
      end
      @(posedge clk); #1;
      k++;
    end
    stall = 1'b0;
    e_we = 0; e_done = 1; e_busy = 1; e_ready = 0;
    @(posedge clk); #1;
    e_done = 0; e_busy = 0; e_ready = 1;
  endtask

  initial begin
    int ex[6];
    int ey[6];
    ex = '{10, 11, 12, 10, 11, 12};
    ey = '{20, 20, 20, 21, 21, 21};

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    arstn = 1'b1;
    e_ready = 1;
    check("rst_addr_x", addr_x, 0);
    check("rst_addr_y", addr_y, 0);
    check("rst_color", color, 0);
    @(posedge clk); #1;

    run_cmd(5, 7, 5, 7, 1, 32'h0);
    check("single_count", log_x.size(), 1);
    check("single_x", log_x[0], 5);
    check("single_y", log_y[0], 7);
    check("single_done_lbl", done_lbl, 2);

    run_cmd(10, 20, 12, 21, 2, 32'h0);
    check("rect_count", log_x.size(), 6);
    for (int i = 0; i < 6 && i < log_x.size(); i++) begin
      check("rect_x", log_x[i], ex[i]);
      check("rect_y", log_y[i], ey[i]);
    end
    check("rect_done_lbl", done_lbl, 7);

    run_cmd(1278, 1022, 2000, 2000, 3, 32'h0);
    check("clip_count", log_x.size(), 4);
    if (log_x.size() == 4) begin
      check("clip_first_x", log_x[0], 1278);
      check("clip_first_y", log_y[0], 1022);
      check("clip_last_x", log_x[3], 1279);
      check("clip_last_y", log_y[3], 1023);
    end
    check("clip_done_lbl", done_lbl, 5);

    run_cmd(30, 5, 20, 5, 0, 32'h0);
    check("empty1_count", log_x.size(), 0);
    check("empty1_done_lbl", done_lbl, 1);
    run_cmd(1280, 0, 1290, 0, 1, 32'h0);
    check("empty2_count", log_x.size(), 0);
    check("empty2_done_lbl", done_lbl, 1);

    run_cmd(0, 0, 2, 0, 1, 32'b1100);
    check("stall_count", log_x.size(), 3);
    for (int i = 0; i < 3 && i < log_x.size(); i++) check("stall_x", log_x[i], i);
    check("stall_done_lbl", done_lbl, 6);

    run_cmd(7, 9, 8, 9, 2, 32'b1010);
    check("stall_edge_count", log_x.size(), 2);
    check("stall_edge_done_lbl", done_lbl, 5);

    // 4x4 command aborted by reset after its fifth write
    issue(100, 200, 103, 203, 3);
    for (int p = 0; p < 5; p++) begin
      e_ready = 0; e_busy = 1; e_done = 0; e_we = 1;
      e_x = 11'(100 + p % 4);
      e_y = 11'(200 + p / 4);
      e_c = 2'd3;
      @(posedge clk); #1;
    end
    arstn = 1'b0;
    e_we = 0; e_busy = 0; e_done = 0; e_ready = 0;
    @(posedge clk); #1;
    arstn = 1'b1;
    e_ready = 1;
    check("abort_addr_x", addr_x, 0);
    check("abort_addr_y", addr_y, 0);
    check("abort_color", color, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_count", log_x.size(), 5);
    check("abort_no_done", done_lbl, -1);

    run_cmd(50, 60, 50, 60, 2, 32'h0);
    check("post_count", log_x.size(), 1);
    check("post_done_lbl", done_lbl, 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
